// File: rtl/sha2_sigma_unit.sv
// SHA-2 sigma CFU: sig0/sig1/Sum0/Sum1 for SHA-256 (WIDTH=32) or SHA-512 (WIDTH=64) behind a
// stallable valid/ready pipeline. Optional macro SHA2_SIGMA_SCHED_EN enables func 4 (schedule word).
module sha2_sigma_unit #(
  parameter int WIDTH       = 32,
  parameter int PIPE_STAGES = 1,
  parameter int ID_W        = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_func,
  input  logic [ID_W-1:0]  req_id,
  input  logic [WIDTH-1:0] req_data0,
  input  logic [WIDTH-1:0] req_data1,
  input  logic [WIDTH-1:0] req_data2,
  input  logic [WIDTH-1:0] req_data3,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic [ID_W-1:0]  resp_id
);

  localparam bit W64  = (WIDTH == 64);
  localparam int LAST = PIPE_STAGES - 1;

  if (!(WIDTH == 32 || WIDTH == 64)) begin : g_bad_width
    $error("sha2_sigma_unit: WIDTH must be 32 or 64");
  end
  if (PIPE_STAGES < 1 || PIPE_STAGES > 3) begin : g_bad_depth
    $error("sha2_sigma_unit: PIPE_STAGES must be 1..3");
  end

  function automatic logic [WIDTH-1:0] ror(input logic [WIDTH-1:0] x, input int n);
    ror = (x >> n) | (x << (WIDTH - n));
  endfunction

  function automatic logic [WIDTH-1:0] small_sig0(input logic [WIDTH-1:0] x);
    small_sig0 = ror(x, W64 ? 1 : 7) ^ ror(x, W64 ? 8 : 18) ^ (x >> (W64 ? 7 : 3));
  endfunction

  function automatic logic [WIDTH-1:0] small_sig1(input logic [WIDTH-1:0] x);
    small_sig1 = ror(x, W64 ? 19 : 17) ^ ror(x, W64 ? 61 : 19) ^ (x >> (W64 ? 6 : 10));
  endfunction

  function automatic logic [WIDTH-1:0] big_sum0(input logic [WIDTH-1:0] x);
    big_sum0 = ror(x, W64 ? 28 : 2) ^ ror(x, W64 ? 34 : 13) ^ ror(x, W64 ? 39 : 22);
  endfunction

  function automatic logic [WIDTH-1:0] big_sum1(input logic [WIDTH-1:0] x);
    big_sum1 = ror(x, W64 ? 14 : 6) ^ ror(x, W64 ? 18 : 11) ^ ror(x, W64 ? 41 : 25);
  endfunction

`ifdef SHA2_SIGMA_SCHED_EN
  // 3:2 compressor returning {carry, sum}; the carry's top bit is dropped (mod 2^WIDTH)
  function automatic logic [2*WIDTH-1:0] csa(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                            input logic [WIDTH-1:0] c);
    csa = {((a & b) | (a & c) | (b & c)) << 1, a ^ b ^ c};
  endfunction

  logic [WIDTH-1:0] sig1_term_s, sig0_term_s, csa1_s_s, csa1_c_s, csa2_s_s, csa2_c_s, sched_s;

  assign sig1_term_s            = small_sig1(req_data0);
  assign sig0_term_s            = small_sig0(req_data2);
  assign {csa1_c_s, csa1_s_s}   = csa(sig1_term_s, req_data1, sig0_term_s);
  assign {csa2_c_s, csa2_s_s}   = csa(csa1_s_s, csa1_c_s, req_data3);
  assign sched_s                = csa2_s_s + csa2_c_s;
`else
  logic unused_sched_s;
  assign unused_sched_s = ^{req_data1, req_data2, req_data3};
`endif

  logic [WIDTH-1:0]       result_s;
  logic [PIPE_STAGES-1:0] load_s;
  logic [PIPE_STAGES-1:0] valid_q, valid_d;
  logic [WIDTH-1:0]       data_q [PIPE_STAGES];
  logic [WIDTH-1:0]       data_d [PIPE_STAGES];
  logic [ID_W-1:0]        id_q   [PIPE_STAGES];
  logic [ID_W-1:0]        id_d   [PIPE_STAGES];

  always_comb begin
    result_s = {WIDTH{1'b0}};
    case (req_func)
      3'd0: result_s = small_sig0(req_data0);
      3'd1: result_s = small_sig1(req_data0);
      3'd2: result_s = big_sum0(req_data0);
      3'd3: result_s = big_sum1(req_data0);
`ifdef SHA2_SIGMA_SCHED_EN
      3'd4: result_s = sched_s;
`endif
      default: result_s = {WIDTH{1'b0}};
    endcase
  end

  // A stage may load when empty or when its contents leave this edge; evaluated back to front.
  always_comb begin
    load_s       = {PIPE_STAGES{1'b0}};
    load_s[LAST] = !valid_q[LAST] || resp_ready;
    for (int k = LAST - 1; k >= 0; k--) begin
      load_s[k] = !valid_q[k] || load_s[k + 1];
    end
  end

  always_comb begin
    valid_d = valid_q;
    for (int k = 0; k < PIPE_STAGES; k++) begin
      data_d[k] = data_q[k];
      id_d[k]   = id_q[k];
    end
    if (load_s[0]) begin
      valid_d[0] = req_valid;
      if (req_valid) begin
        data_d[0] = result_s;
        id_d[0]   = req_id;
      end else begin
        data_d[0] = data_q[0];
      end
    end else begin
      valid_d[0] = valid_q[0];
    end
    for (int k = 1; k < PIPE_STAGES; k++) begin
      if (load_s[k]) begin
        valid_d[k] = valid_q[k - 1];
        if (valid_q[k - 1]) begin
          data_d[k] = data_q[k - 1];
          id_d[k]   = id_q[k - 1];
        end else begin
          data_d[k] = data_q[k];
        end
      end else begin
        valid_d[k] = valid_q[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= {PIPE_STAGES{1'b0}};
      for (int k = 0; k < PIPE_STAGES; k++) begin
        data_q[k] <= {WIDTH{1'b0}};
        id_q[k]   <= {ID_W{1'b0}};
      end
    end else begin
      valid_q <= valid_d;
      for (int k = 0; k < PIPE_STAGES; k++) begin
        data_q[k] <= data_d[k];
        id_q[k]   <= id_d[k];
      end
    end
  end

  assign req_ready  = load_s[0];
  assign resp_valid = valid_q[LAST];
  assign resp_data  = data_q[LAST];
  assign resp_id    = id_q[LAST];

endmodule

// File: tb/tb_sha2_sigma_unit.sv
// Scoreboard bench for sha2_sigma_unit: a 32-bit/1-stage instance (A) and a 64-bit/3-stage instance (B).
module tb_sha2_sigma_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_req_valid, a_req_ready, a_resp_valid, a_resp_ready;
  logic [2:0]  a_req_func;
  logic [3:0]  a_req_id, a_resp_id;
  logic [31:0] a_d0, a_d1, a_d2, a_d3, a_resp_data;
  logic        b_req_valid, b_req_ready, b_resp_valid, b_resp_ready;
  logic [2:0]  b_req_func;
  logic [3:0]  b_req_id, b_resp_id;
  logic [63:0] b_d0, b_d1, b_d2, b_d3, b_resp_data;

  sha2_sigma_unit #(.WIDTH(32), .PIPE_STAGES(1), .ID_W(4)) u_a (
    .clk(clk), .rst(rst), .req_valid(a_req_valid), .req_ready(a_req_ready), .req_func(a_req_func),
    .req_id(a_req_id), .req_data0(a_d0), .req_data1(a_d1), .req_data2(a_d2), .req_data3(a_d3),
    .resp_valid(a_resp_valid), .resp_ready(a_resp_ready), .resp_data(a_resp_data), .resp_id(a_resp_id));

  sha2_sigma_unit #(.WIDTH(64), .PIPE_STAGES(3), .ID_W(4)) u_b (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_func(b_req_func),
    .req_id(b_req_id), .req_data0(b_d0), .req_data1(b_d1), .req_data2(b_d2), .req_data3(b_d3),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_data(b_resp_data), .resp_id(b_resp_id));

  typedef struct packed {
    logic [63:0] data;
    logic [3:0]  id;
    int          cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic a_lat_chk = 1'b0;

`ifdef SHA2_SIGMA_SCHED_EN
  localparam logic [31:0] SCHED_V1 = 32'h0200E005;
  localparam logic [31:0] SCHED_V2 = 32'h00000001;
`else
  localparam logic [31:0] SCHED_V1 = 32'h00000000;
  localparam logic [31:0] SCHED_V2 = 32'h00000000;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] r32(input logic [31:0] x, input int n);
    logic [63:0] t;
    t = {x, x} >> n;
    return t[31:0];
  endfunction

  function automatic logic [31:0] ref32(input logic [2:0] f, input logic [31:0] d0, input logic [31:0] d1,
                                        input logic [31:0] d2, input logic [31:0] d3);
    logic [31:0] s0, s1;
    s1 = r32(d0, 17) ^ r32(d0, 19) ^ (d0 >> 10);
    s0 = r32(d2, 7) ^ r32(d2, 18) ^ (d2 >> 3);
    case (f)
      3'd0: return r32(d0, 7) ^ r32(d0, 18) ^ (d0 >> 3);
      3'd1: return s1;
      3'd2: return r32(d0, 2) ^ r32(d0, 13) ^ r32(d0, 22);
      3'd3: return r32(d0, 6) ^ r32(d0, 11) ^ r32(d0, 25);
`ifdef SHA2_SIGMA_SCHED_EN
      3'd4: return s1 + d1 + s0 + d3;
`endif
      default: return 32'h0;
    endcase
  endfunction

  // Monitor A: pops the scoreboard on every transfer and checks hold-while-stalled.
  logic        a_stall = 1'b0;
  logic [31:0] a_hold_d;
  logic [3:0]  a_hold_id;
  always @(negedge clk) begin
    if (rst) begin
      a_stall <= 1'b0;
    end else begin
      if (a_stall) begin
        chk("a_hold_valid", a_resp_valid, 1'b1);
        chk("a_hold_data", a_resp_data, a_hold_d);
        chk("a_hold_id", a_resp_id, a_hold_id);
      end
      if (a_resp_valid && a_resp_ready) begin
        chk("a_resp_expected", 64'(qa.size() != 0), 64'd1);
        if (qa.size() != 0) begin
          exp_t e;
          e = qa.pop_front();
          chk("a_data", a_resp_data, e.data);
          chk("a_id", a_resp_id, e.id);
          if (a_lat_chk) chk("a_latency", 64'(cyc - e.cyc), 64'd1);
        end
      end
      a_stall   <= a_resp_valid && !a_resp_ready;
      a_hold_d  <= a_resp_data;
      a_hold_id <= a_resp_id;
    end
  end

  logic        b_stall = 1'b0;
  logic [63:0] b_hold_d;
  logic [3:0]  b_hold_id;
  always @(negedge clk) begin
    if (rst) begin
      b_stall <= 1'b0;
    end else begin
      if (b_stall) begin
        chk("b_hold_valid", b_resp_valid, 1'b1);
        chk("b_hold_data", b_resp_data, b_hold_d);
        chk("b_hold_id", b_resp_id, b_hold_id);
      end
      if (b_resp_valid && b_resp_ready) begin
        chk("b_resp_expected", 64'(qb.size() != 0), 64'd1);
        if (qb.size() != 0) begin
          exp_t e;
          e = qb.pop_front();
          chk("b_data", b_resp_data, e.data);
          chk("b_id", b_resp_id, e.id);
        end
      end
      b_stall   <= b_resp_valid && !b_resp_ready;
      b_hold_d  <= b_resp_data;
      b_hold_id <= b_resp_id;
    end
  end

  // Presents one request to A from posedge+1 and pushes its expectation once it will be accepted.
  task automatic send_a(input logic [2:0] f, input logic [3:0] id, input logic [31:0] d0, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] d3, input logic [31:0] exp);
    int n;
    n = 0;
    a_req_valid = 1'b1; a_req_func = f; a_req_id = id;
    a_d0 = d0; a_d1 = d1; a_d2 = d2; a_d3 = d3;
    while (1) begin
      @(negedge clk);
      if (a_req_ready) begin
        qa.push_back('{data: 64'(exp), id: id, cyc: cyc});
        break;
      end
      n++;
      if (n > 200) begin
        chk("a_accept_timeout", 64'(n), 64'd0);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    a_req_valid = 1'b0;
  endtask

  logic [2:0]  b_func_tbl [5] = '{3'd1, 3'd0, 3'd2, 3'd3, 3'd5};
  logic [63:0] b_exp_tbl  [5] = '{64'h0000200000000008, 64'h8100000000000000, 64'h0000001042000000,
                                  64'h0004400000800000, 64'h0000000000000000};

  task automatic set_b(input int k);
    b_req_valid = 1'b1; b_req_func = b_func_tbl[k]; b_req_id = 4'(k);
    b_d0 = 64'd1; b_d1 = 64'd0; b_d2 = 64'd0; b_d3 = 64'd0;
  endtask

  logic rand_done = 1'b0;

  initial begin
    int acc;
    int n;
    rst = 1'b1;
    a_req_valid = 1'b0; a_req_func = 3'd0; a_req_id = 4'd0; a_resp_ready = 1'b1;
    a_d0 = 32'd0; a_d1 = 32'd0; a_d2 = 32'd0; a_d3 = 32'd0;
    b_req_valid = 1'b0; b_req_func = 3'd0; b_req_id = 4'd0; b_resp_ready = 1'b0;
    b_d0 = 64'd0; b_d1 = 64'd0; b_d2 = 64'd0; b_d3 = 64'd0;
    #1;
    chk("a_rst_valid", a_resp_valid, 1'b0);
    chk("a_rst_data", a_resp_data, 32'd0);
    chk("a_rst_id", a_resp_id, 4'd0);
    chk("b_rst_valid", b_resp_valid, 1'b0);
    chk("b_rst_data", b_resp_data, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("a_ready_after_rst", a_req_ready, 1'b1);
    chk("b_ready_after_rst", b_req_ready, 1'b1);
    @(posedge clk); #1;

    // Back-to-back directed vectors on A, each expected exactly one cycle after accept.
    a_lat_chk = 1'b1;
    send_a(3'd0, 4'd1, 32'h00000001, 32'd0, 32'd0, 32'd0, 32'h02004000);
    send_a(3'd1, 4'd2, 32'h00000001, 32'd0, 32'd0, 32'd0, 32'h0000A000);
    send_a(3'd2, 4'd3, 32'h00000001, 32'd0, 32'd0, 32'd0, 32'h40080400);
    send_a(3'd3, 4'd4, 32'h00000001, 32'd0, 32'd0, 32'd0, 32'h04200080);
    send_a(3'd4, 4'd5, 32'h00000001, 32'h00000002, 32'h00000001, 32'h00000003, SCHED_V1);
    send_a(3'd4, 4'd6, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000002, SCHED_V2);
    send_a(3'd7, 4'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
    send_a(3'd0, 4'd8, 32'h80000000, 32'd0, 32'd0, 32'd0, 32'h11002000);
    repeat (3) @(posedge clk); #1;
    a_lat_chk = 1'b0;
    chk("a_directed_drained", 64'(qa.size()), 64'd0);

    // B: fill the 3-stage pipe with resp_ready low, then drain.
    b_resp_ready = 1'b0;
    acc = 0;
    set_b(0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (b_req_ready) begin
        qb.push_back('{data: b_exp_tbl[acc], id: 4'(acc), cyc: cyc});
        acc++;
      end
      @(posedge clk); #1;
      set_b(acc);
    end
    chk("b_fill_accepted", 64'(acc), 64'd3);
    @(negedge clk);
    chk("b_full_ready", b_req_ready, 1'b0);
    @(posedge clk); #1;
    b_resp_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("b_drain_contiguous", b_resp_valid, 1'b1);
      if (b_req_valid && b_req_ready) begin
        qb.push_back('{data: b_exp_tbl[acc], id: 4'(acc), cyc: cyc});
        acc++;
      end
      @(posedge clk); #1;
      if (acc < 5) set_b(acc);
      else b_req_valid = 1'b0;
    end
    chk("b_drain_accepted", 64'(acc), 64'd5);
    repeat (2) @(posedge clk); #1;
    chk("b_drain_empty", 64'(qb.size()), 64'd0);

    // Asynchronous reset with two results in flight and the consumer stalled.
    b_resp_ready = 1'b0;
    b_req_valid = 1'b1; b_req_func = 3'd0; b_req_id = 4'd7; b_d0 = 64'd1;
    @(posedge clk); #1;
    b_req_id = 4'd8;
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("b_pre_rst_valid", b_resp_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("b_async_valid", b_resp_valid, 1'b0);
    chk("b_async_data", b_resp_data, 64'd0);
    chk("b_async_id", b_resp_id, 4'd0);
    qb.delete();
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    b_resp_ready = 1'b1;
    @(negedge clk);
    chk("b_ready_post_rst", b_req_ready, 1'b1);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("b_no_ghost", b_resp_valid, 1'b0);
    @(posedge clk); #1;

    // Random traffic on A against the reference model, with random consumer stalls.
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          logic [2:0]  f;
          logic [31:0] r0, r1, r2, r3;
          f = 3'($urandom_range(0, 7));
          r0 = $urandom; r1 = $urandom; r2 = $urandom; r3 = $urandom;
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
          end
          send_a(f, 4'(i), r0, r1, r2, r3, ref32(f, r0, r1, r2, r3));
        end
        n = 0;
        while (qa.size() != 0 && n < 500) begin
          @(posedge clk); #1;
          n++;
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          a_resp_ready = ($urandom_range(0, 3) != 0);
        end
        a_resp_ready = 1'b1;
      end
    join
    chk("a_random_drained", 64'(qa.size()), 64'd0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha2_sigma_unit.md
Name: sha2_sigma_unit

Overview:
Parametrised SHA-2 sigma CFU for the CVA5 custom-function path. It covers all four SHA-2 sigma functions, supports SHA-256 (32-bit) or SHA-512 (64-bit) word size, and uses valid/ready handshakes with a stall-capable pipeline of configurable depth. Requests come from the CFU issue interface and responses return to writeback tagged with an ID.

Parameters:
WIDTH, 32, word size; only 32 (SHA-256 constants) or 64 (SHA-512 constants) are legal.
PIPE_STAGES, 1, number of registered stages (1..3); latency equals PIPE_STAGES.
ID_W, 4, width of the request tag carried through to the response.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  request present
req_ready  out  1  unit accepts request this cycle
req_func  in  3  function select
req_id  in  ID_W  request tag
req_data0  in  WIDTH  operand x, or W[t-2] in schedule mode
req_data1  in  WIDTH  W[t-7] (schedule mode only)
req_data2  in  WIDTH  W[t-15] (schedule mode only)
req_data3  in  WIDTH  W[t-16] (schedule mode only)
resp_valid  out  1  result present
resp_ready  in  1  consumer accepts result
resp_data  out  WIDTH  result
resp_id  out  ID_W  tag of result

Behaviour:
- Reset: rst asserted, asynchronous and active-high. All stage valid bits, resp_valid, resp_data and resp_id clear to 0. In-flight requests are dropped. req_ready is 1 in the first cycle after release.
- Functions for WIDTH=32: 0 = sig0 (ror7^ror18^shr3), 1 = sig1 (ror17^ror19^shr10), 2 = Sum0 (ror2^ror13^ror22), 3 = Sum1 (ror6^ror11^ror25).
- Functions for WIDTH=64: 0 = sig0 (ror1^ror8^shr7), 1 = sig1 (ror19^ror61^shr6), 2 = Sum0 (ror28^ror34^ror39), 3 = Sum1 (ror14^ror18^ror41).
- func 4..7: result 0 unless enabled by the optional feature.
- Datapath: result is computed combinationally from the request and captured into stage 1 on the accept edge. Stages 2..PIPE_STAGES only carry {valid, data, id}. resp_* are driven directly from the last stage.
- Handshake: transfer occurs on a clock edge where valid && ready. Once resp_valid is high, resp_data and resp_id stay stable until resp_ready.
- Stall rule: stage k advances when stage k+1 is empty or advancing. The last stage advances when resp_ready is high. Bubbles collapse.
- req_ready = !stage1.valid || stage1 advancing. This is combinational from resp_ready through the stage valids; there is no path from req_valid.
- Throughput: one result per cycle with resp_ready held high. Latency is PIPE_STAGES cycles from accept to resp_valid.
- Full pipeline with resp_ready=0: req_ready=0 and nothing is lost or duplicated. A simultaneous accept and drain in the same cycle proceeds normally.
- Ordering: responses are strictly in request order.
- Illegal WIDTH: elaboration error.

Optional Feature:
SHA2_SIGMA_SCHED_EN
- Defined: func 4 = message-schedule word, computed as sig1(data0) + data1 + sig0(data2) + data3, modulo 2^WIDTH. The add tree is split so that the sigma terms finish in the request cycle and the 4-input sum uses a carry-save stage before stage 1. Latency is unchanged. func 5..7 return 0.
- Undefined: func 4..7 return 0. req_data1..3 are ignored, and the ports remain present so the interface is stable.

Test Plan:
- WIDTH=32, PIPE_STAGES=1, resp_ready=1: issue func 0..3 with data0=0x00000001 back-to-back. Responses are 0x02004000, 0x0000A000, 0x40080400, 0x04200080 on consecutive cycles, each one cycle after its request, with matching ids.
- WIDTH=64: func 1, data0=1 -> 0x0000200000000008.
- PIPE_STAGES=3 with resp_ready=0 and 5 requests offered: exactly 3 accepted, then req_ready=0. Raising resp_ready drains all 5 in order with ids 0..4, with no gaps once flowing.
- SHA2_SIGMA_SCHED_EN defined, func 4:
  - data0=1, data1=2, data2=1, data3=3 -> 0x0200E005.
  - data0=0, data1=0xFFFFFFFF, data2=0, data3=2 -> 0x00000001 (wrap).
  - With the macro undefined, the same requests -> 0.
- Assert rst mid-stream with 2 results in flight and resp_ready=0: resp_valid drops to 0 immediately (asynchronous), and neither in-flight result ever appears after release.
- Random valid/ready toggling, 1000 requests: the response sequence matches a reference model exactly, with no drops or duplicates, and resp_data is stable while stalled.
